// File: rtl/led_display_row_driver.sv
// ============================================================================
//  Module      : led_display_row_driver
//  Description : Accepts one scan-row pair of RGB pixel data over a
//                valid/ready interface. Serialises it onto a HUB75-style
//                panel bus, then blanks, updates the address, latches, and
//                lights the panel for a fixed time before taking the next row.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_display_row_driver #(
    parameter int NUM_COL_PIXELS = 64,
    parameter int BCLK_DIV       = 4,
    parameter int LATCH_CYCLES   = 2,
    parameter int DISPLAY_CYCLES = 256
) (
    input  logic                        clk_in,
    input  logic                        n_reset_in,
    input  logic [6*NUM_COL_PIXELS-1:0] row_in,
    input  logic                        row_valid_in,
    output logic                        row_ready_out,
    input  logic [3:0]                  row_address_in,
    output logic                        bclk_out,
    output logic [2:0]                  rgb0_out,
    output logic [2:0]                  rgb1_out,
    output logic                        latch_out,
    output logic                        blank_out,
    output logic [3:0]                  addr_out
);

    localparam int ROW_W    = 6 * NUM_COL_PIXELS;
    localparam int HALF_DIV = BCLK_DIV / 2;
    localparam int COL_W    = (NUM_COL_PIXELS > 1) ? $clog2(NUM_COL_PIXELS) : 1;
    localparam int PH_W     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int HOLD_MAX = (LATCH_CYCLES > DISPLAY_CYCLES) ? LATCH_CYCLES : DISPLAY_CYCLES;
    localparam int CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [COL_W-1:0] c_LAST_COL   = COL_W'(NUM_COL_PIXELS - 1);
    localparam logic [PH_W-1:0]  c_PH_RISE    = PH_W'(HALF_DIV - 1);
    localparam logic [PH_W-1:0]  c_PH_LAST    = PH_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DISP_LAST  = CNT_W'(DISPLAY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_BLANK   = 3'd2,
        S_LATCH   = 3'd3,
        S_DISPLAY = 3'd4
    } state_t;

    state_t             r_state;
    logic [ROW_W-1:0]   r_row;       // columns still to be shifted, next column in [5:0]
    logic [3:0]         r_addr_cap;  // address captured with the row
    logic [COL_W-1:0]   r_col;       // column currently on the bus
    logic [PH_W-1:0]    r_ph;        // clock index within the current bclk period
    logic [CNT_W-1:0]   r_cnt;       // latch / display duration counter
    logic               r_ready;
    logic               r_bclk;
    logic [2:0]         r_rgb0;
    logic [2:0]         r_rgb1;
    logic               r_latch;
    logic               r_blank;
    logic [3:0]         r_addr;

    // Row sequencer: capture, shift out, blank, latch, display, then back to idle.
    // Every panel output is a register so the bus never sees combinational glitches.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_addr_cap <= '0;
            r_col      <= '0;
            r_ph       <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_bclk     <= 1'b0;
            r_rgb0     <= '0;
            r_rgb1     <= '0;
            r_latch    <= 1'b0;
            r_blank    <= 1'b1;
            r_addr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Ready is always high here, so valid alone completes the handshake.
                    // Column 0 is placed on the bus straight away so the first
                    // low phase of bclk already carries valid data.
                    if (row_valid_in) begin
                        r_row      <= row_in >> 6;
                        r_addr_cap <= row_address_in;
                        r_rgb0     <= row_in[2:0];
                        r_rgb1     <= row_in[5:3];
                        r_bclk     <= 1'b0;
                        r_col      <= '0;
                        r_ph       <= '0;
                        r_ready    <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (r_ph == c_PH_LAST) begin
                        // End of a bclk period: fall, and either present the
                        // next column or finish the row with a quiet bus.
                        r_ph   <= '0;
                        r_bclk <= 1'b0;
                        if (r_col == c_LAST_COL) begin
                            r_col   <= '0;
                            r_rgb0  <= '0;
                            r_rgb1  <= '0;
                            r_blank <= 1'b1;
                            r_state <= S_BLANK;
                        end else begin
                            r_col  <= r_col + 1'b1;
                            r_rgb0 <= r_row[2:0];
                            r_rgb1 <= r_row[5:3];
                            r_row  <= r_row >> 6;
                        end
                    end else begin
                        r_ph <= r_ph + 1'b1;
                        if (r_ph == c_PH_RISE) begin
                            r_bclk <= 1'b1;
                        end
                    end
                end

                S_BLANK: begin
                    // The address moves one clock after blank rises, so the
                    // row drivers never switch while the panel is lit.
                    r_addr  <= r_addr_cap;
                    r_latch <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_LATCH;
                end

                S_LATCH: begin
                    if (r_cnt == c_LATCH_LAST) begin
                        r_cnt   <= '0;
                        r_latch <= 1'b0;
                        r_blank <= 1'b0;
                        r_state <= S_DISPLAY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DISPLAY: begin
                    // Blank stays low on exit; the panel keeps showing this row.
                    if (r_cnt == c_DISP_LAST) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign row_ready_out = r_ready;
    assign bclk_out      = r_bclk;
    assign rgb0_out      = r_rgb0;
    assign rgb1_out      = r_rgb1;
    assign latch_out     = r_latch;
    assign blank_out     = r_blank;
    assign addr_out      = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_led_display_row_driver.sv
// ============================================================================
//  Module      : tb_led_display_row_driver
//  Description : Scoreboard bench for led_display_row_driver. Stimulus tasks
//                push expected column data, addresses and handshake times;
//                monitors pop them on bclk / latch / ready events.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_display_row_driver;

    localparam int NA = 64;
    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_reset = 1'b1;

    // Default-parameter instance
    logic [6*NA-1:0] a_row = '0;
    logic            a_valid = 1'b0;
    logic [3:0]      a_addr_in = '0;
    logic            a_ready, a_bclk, a_latch, a_blank;
    logic [2:0]      a_rgb0, a_rgb1;
    logic [3:0]      a_addr;

    // Small variant instance
    logic [6*NB-1:0] b_row = '0;
    logic            b_valid = 1'b0;
    logic [3:0]      b_addr_in = '0;
    logic            b_ready, b_bclk, b_latch, b_blank;
    logic [2:0]      b_rgb0, b_rgb1;
    logic [3:0]      b_addr;

    led_display_row_driver u_dut_a (
        .clk_in         (clk),
        .n_reset_in     (n_reset),
        .row_in         (a_row),
        .row_valid_in   (a_valid),
        .row_ready_out  (a_ready),
        .row_address_in (a_addr_in),
        .bclk_out       (a_bclk),
        .rgb0_out       (a_rgb0),
        .rgb1_out       (a_rgb1),
        .latch_out      (a_latch),
        .blank_out      (a_blank),
        .addr_out       (a_addr)
    );

    led_display_row_driver #(
        .NUM_COL_PIXELS (NB),
        .BCLK_DIV       (2),
        .LATCH_CYCLES   (2),
        .DISPLAY_CYCLES (1)
    ) u_dut_b (
        .clk_in         (clk),
        .n_reset_in     (n_reset),
        .row_in         (b_row),
        .row_valid_in   (b_valid),
        .row_ready_out  (b_ready),
        .row_address_in (b_addr_in),
        .bclk_out       (b_bclk),
        .rgb0_out       (b_rgb0),
        .rgb1_out       (b_rgb1),
        .latch_out      (b_latch),
        .blank_out      (b_blank),
        .addr_out       (b_addr)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues
    logic [5:0] qa[$];
    logic [3:0] qa_addr[$];
    int         qa_hs[$];
    logic [5:0] qb[$];
    int         qb_hs[$];
    int         a_last_hs = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with nothing expected (t=%0t)", name, $time);
    endtask

    function automatic logic [6*NA-1:0] mk_row_a(input int seed);
        logic [6*NA-1:0] r;
        r = '0;
        for (int c = 0; c < NA; c++) r[6*c +: 6] = 6'((c + seed * 7) & 63);
        return r;
    endfunction

    function automatic logic [6*NB-1:0] mk_row_b(input int seed);
        logic [6*NB-1:0] r;
        r = '0;
        for (int c = 0; c < NB; c++) r[6*c +: 6] = 6'((c * 5 + seed + 1) & 63);
        return r;
    endfunction

    // Present a row; when ready is seen the handshake happens on the next edge,
    // so the expected columns, address and handshake cycle are queued then.
    task automatic send_a(input int seed, input logic [3:0] a, input bit hold, input int exp_gap);
        logic [6*NA-1:0] d;
        int n;
        bit ok;
        d = mk_row_a(seed);
        a_row = d; a_addr_in = a; a_valid = 1'b1;
        n = 0; ok = 1'b1;
        @(negedge clk);
        while (!a_ready) begin
            n++;
            if (n > 2000) begin ok = 1'b0; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("a_handshake_timeout", n, 0);
        end else begin
            for (int c = 0; c < NA; c++) qa.push_back(d[6*c +: 6]);
            qa_addr.push_back(a);
            if (exp_gap != 0) chk("a_handshake_gap", cyc - a_last_hs, exp_gap);
            a_last_hs = cyc;
            qa_hs.push_back(cyc);
        end
        @(posedge clk); #1;
        if (!hold) a_valid = 1'b0;
    endtask

    task automatic send_b(input int seed, input logic [3:0] a);
        logic [6*NB-1:0] d;
        int n;
        bit ok;
        d = mk_row_b(seed);
        b_row = d; b_addr_in = a; b_valid = 1'b1;
        n = 0; ok = 1'b1;
        @(negedge clk);
        while (!b_ready) begin
            n++;
            if (n > 200) begin ok = 1'b0; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("b_handshake_timeout", n, 0);
        end else begin
            for (int c = 0; c < NB; c++) qb.push_back(d[6*c +: 6]);
            qb_hs.push_back(cyc);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic wait_ready_a();
        int n;
        n = 0;
        @(negedge clk);
        while (!a_ready) begin
            n++;
            if (n > 2000) break;
            @(negedge clk);
        end
        if (n > 2000) chk("a_ready_timeout", n, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_ready_b();
        int n;
        n = 0;
        @(negedge clk);
        while (!b_ready) begin
            n++;
            if (n > 200) break;
            @(negedge clk);
        end
        if (n > 200) chk("b_ready_timeout", n, 0);
        @(posedge clk); #1;
    endtask

    // Monitor for the default instance, sampling on the falling edge.
    logic pa_bclk = 1'b0, pa_latch = 1'b0, pa_blank = 1'b1, pa_ready = 1'b1;
    logic [3:0] pa_addr = '0;
    int a_edges = 0, a_lat_len = 0, a_disp_len = 0, a_tot_edges = 0;
    always @(negedge clk) begin
        if (n_reset) begin
            if (a_bclk && !pa_bclk) begin
                a_edges++;
                a_tot_edges++;
                if (qa.size() == 0) note_fail("a_bclk_edge");
                else chk("a_rgb_column", {a_rgb1, a_rgb0}, qa.pop_front());
            end
            if (a_latch && !pa_latch) begin
                chk("a_edges_before_latch", a_edges, NA);
                a_edges = 0;
                chk("a_blank_at_latch", a_blank, 1);
                if (qa_addr.size() == 0) note_fail("a_latch_pulse");
                else chk("a_addr_at_latch", a_addr, qa_addr.pop_front());
                a_lat_len = 0;
                a_disp_len = 0;
            end
            if (a_latch) a_lat_len++;
            if (!a_latch && pa_latch) chk("a_latch_len", a_lat_len, 2);
            if (!a_blank && !a_ready) a_disp_len++;
            if (a_ready && !pa_ready) begin
                chk("a_display_len", a_disp_len, 256);
                if (qa_hs.size() == 0) note_fail("a_ready_rise");
                else chk("a_ready_latency", cyc - qa_hs.pop_front(), 516);
            end
            if (a_addr != pa_addr) chk("a_addr_change_blanked", a_blank, 1);
            if (a_blank && !pa_blank) chk("a_bus_quiet_at_blank", {a_bclk, a_rgb1, a_rgb0}, 0);
        end
        pa_bclk = a_bclk; pa_latch = a_latch; pa_blank = a_blank;
        pa_ready = a_ready; pa_addr = a_addr;
    end

    // Monitor for the small variant instance.
    logic pb_bclk = 1'b0, pb_latch = 1'b0, pb_ready = 1'b1;
    int b_edges = 0;
    always @(negedge clk) begin
        if (n_reset) begin
            if (b_bclk && !pb_bclk) begin
                b_edges++;
                if (qb.size() == 0) note_fail("b_bclk_edge");
                else chk("b_rgb_column", {b_rgb1, b_rgb0}, qb.pop_front());
            end
            if (b_latch && !pb_latch) begin
                chk("b_edges_before_latch", b_edges, NB);
                b_edges = 0;
            end
            if (b_ready && !pb_ready) begin
                if (qb_hs.size() == 0) note_fail("b_ready_rise");
                else chk("b_ready_latency", cyc - qb_hs.pop_front(), 21);
            end
        end
        pb_bclk = b_bclk; pb_latch = b_latch; pb_ready = b_ready;
    end

    initial begin
        int e0;

        // Reset values
        #1 n_reset = 1'b0;
        #1;
        chk("rst_ready", a_ready, 1);
        chk("rst_bclk", a_bclk, 0);
        chk("rst_rgb", {a_rgb1, a_rgb0}, 0);
        chk("rst_latch", a_latch, 0);
        chk("rst_blank", a_blank, 1);
        chk("rst_addr", a_addr, 0);
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;

        // Idle: no activity without valid
        e0 = a_tot_edges;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (i % 100 == 99) chk("idle_bclk_latch_blank_ready", {a_bclk, a_latch, a_blank, a_ready}, 4'b0011);
        end
        chk("idle_no_edges", a_tot_edges - e0, 0);

        // Single row, column c carries c, address 5
        send_a(0, 4'h5, 1'b0, 0);
        wait_ready_a();
        chk("row1_addr_out", a_addr, 5);
        chk("row1_blank_out", a_blank, 0);

        // Backpressure: valid held with changing data while busy
        send_a(3, 4'h9, 1'b1, 0);
        for (int i = 0; i < 300; i++) begin
            a_row = {12{$urandom()}};
            a_addr_in = 4'($urandom_range(0, 15));
            if (i % 50 == 0) chk("busy_ready_low", a_ready, 0);
            @(posedge clk); #1;
        end
        send_a(4, 4'hA, 1'b0, 516);
        wait_ready_a();

        // Back-to-back: 16 rows, valid always high
        for (int i = 0; i < 16; i++) send_a(10 + i, 4'(i), 1'b1, (i == 0) ? 0 : 516);
        a_valid = 1'b0;
        wait_ready_a();
        chk("b2b_final_addr", a_addr, 15);

        // Parameter variant
        send_b(1, 4'h2);
        wait_ready_b();
        send_b(2, 4'h3);
        wait_ready_b();

        // Asynchronous reset in the middle of a shift (bclk high here)
        send_a(5, 4'h3, 1'b0, 0);
        repeat (102) @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        chk("midrst_bclk", a_bclk, 0);
        chk("midrst_rgb", {a_rgb1, a_rgb0}, 0);
        chk("midrst_latch", a_latch, 0);
        chk("midrst_blank", a_blank, 1);
        chk("midrst_addr", a_addr, 0);
        qa.delete(); qa_addr.delete(); qa_hs.delete();
        a_edges = 0;
        @(posedge clk); #1 n_reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", a_ready, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_quiet", {a_bclk, a_latch, a_blank, a_ready}, 4'b0011);

        chk("scoreboard_drained", qa.size() + qa_addr.size() + qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_display_row_driver.md
Name: led_display_row_driver

Overview:
- Row consumer and panel PHY on the far side of the pattern generator's row valid/ready interface.
- Accepts one scan-row pair of RGB pixel data plus a 4-bit row address via valid/ready.
- Serialises the pair onto a HUB75-style panel bus (bclk, rgb0, rgb1, latch, blank, addr).
- Holds the latched row on display for a fixed time, then requests the next row.

Parameters:
- NUM_COL_PIXELS, 64: pixels per row; shift periods per row.
- BCLK_DIV, 4: system clocks per bclk period; even, at least 2. bclk low for BCLK_DIV/2 clocks, then high for BCLK_DIV/2.
- LATCH_CYCLES, 2: clocks latch_out is held high.
- DISPLAY_CYCLES, 256: clocks the panel is lit after each latch. Must be at least 1.

Ports:
- clk_in, input, 1: system clock.
- n_reset_in, input, 1: asynchronous active-low reset.
- row_in, input, 6*NUM_COL_PIXELS: pixel data. Column c occupies bits [6c+5:6c], ordered {b1,g1,r1,b0,g0,r0}. Suffix 0 is the upper half-panel row, suffix 1 the lower.
- row_valid_in, input, 1: row_in and row_address_in are valid.
- row_ready_out, output, 1: block can accept a row.
- row_address_in, input, 4: scan-row address for this row pair.
- bclk_out, output, 1: panel shift clock; panel samples on rising edge.
- rgb0_out, output, 3: {b,g,r}, upper half.
- rgb1_out, output, 3: {b,g,r}, lower half.
- latch_out, output, 1: panel latch strobe, active high.
- blank_out, output, 1: panel output disable, active high.
- addr_out, output, 4: panel row address.

Behaviour:
- Reset values (async, effective immediately, any state):
  - state = IDLE, row_ready_out = 1.
  - bclk_out = 0, rgb0_out = 0, rgb1_out = 0, latch_out = 0.
  - blank_out = 1, addr_out = 0.
  - all counters = 0.
- All outputs are registered.
- IDLE:
  - row_ready_out = 1.
  - On row_valid_in & row_ready_out at a rising edge: capture row_in and row_address_in, drop row_ready_out, go to SHIFT.
  - No handshake: stay in IDLE; row_in is ignored while valid is low.
- SHIFT:
  - Column counter col runs 0..NUM_COL_PIXELS-1; column 0 is shifted first.
  - For each column, rgb0_out/rgb1_out update to column col while bclk_out is low.
  - bclk_out is low for BCLK_DIV/2 clocks, then high for BCLK_DIV/2 clocks. Data is stable for the whole period.
  - After the high phase of the last column: bclk_out = 0, rgb outputs = 0, go to BLANK.
  - SHIFT lasts exactly NUM_COL_PIXELS*BCLK_DIV clocks.
- BLANK (1 clock): blank_out = 1; addr_out loads the captured address.
- LATCH (LATCH_CYCLES clocks): latch_out = 1, blank_out stays 1.
- DISPLAY (DISPLAY_CYCLES clocks): latch_out = 0, blank_out = 0.
- After DISPLAY, go to IDLE with blank_out = 0; the panel keeps showing the last row.
- Handshake-to-next-ready latency: 1 + NUM_COL_PIXELS*BCLK_DIV + 1 + LATCH_CYCLES + DISPLAY_CYCLES clocks. With defaults this is 516.
- row_ready_out is low in every state except IDLE. Valid held high while not ready has no effect; data is not captured again.
- The source may change row_in freely after the handshake clock; the captured copy is used.
- Back-to-back rows: row_valid_in held high in IDLE gives a handshake on the first IDLE clock, with no idle gap beyond 1 clock.
- Address equal to the previous address is handled normally; addr_out does not glitch.
- Counters wrap only through the explicit state transitions; no counter rolls past its terminal value.

Test Plan:
- Reset:
  - Assert n_reset_in low mid-SHIFT → same cycle bclk_out=0, blank_out=1, latch_out=0, addr_out=0, rgb=0.
  - Release reset → row_ready_out=1.
- Single row, defaults:
  - row_address_in=4'h5; column c data = {b1,g1,r1,b0,g0,r0} = c[5:0]; one-cycle valid.
  - Exactly 64 bclk rising edges. On each edge, rgb0_out/rgb1_out match column c in order 0..63.
  - Then blank_out=1 and addr_out=5, then latch_out high 2 clocks, then blank_out=0 for 256 clocks.
  - row_ready_out returns high 516 clocks after the handshake.
- Backpressure:
  - Hold row_valid_in=1 with changing row_in during SHIFT → no second capture; shifted data equals the first row.
  - Second row accepted on the first IDLE clock.
- Back-to-back:
  - Feed 16 rows with addresses 0..15 and valid always high.
  - addr_out steps 0..15, each update occurring only while blank_out=1.
  - Each latch pulse is preceded by exactly 64 bclk edges.
- Parameter variant:
  - BCLK_DIV=2, NUM_COL_PIXELS=8, DISPLAY_CYCLES=1 → bclk toggles every clock, 8 edges per row.
  - Ready returns 1+16+1+2+1=21 clocks after the handshake.
- Idle:
  - row_valid_in=0 for 1000 clocks after reset → no bclk edges, latch_out=0, blank_out=1, row_ready_out=1.
